hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Central pipeline sequencer for the 5-stage MIPS core (IF, ID, EXE, MEM, WB).
- Detects load-use hazards and taken branches, and freezes the pipeline while a multi-cycle EXE operation (mult/div/float) or a data-memory wait is in progress.
- Drives write-enable, bubble and flush controls for the PC and the IF_ID, ID_EXE, EXE_MEM and MEM_WB registers.

Parameters:
- MULTI_LAT, 4, cycles a multi-cycle op occupies EXE; legal range 2..16.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EXE instruction is a load.
- ex_rt  in  5  destination register of the EXE load.
- ex_multi_start  in  1  multi-cycle op is in EXE and is being started this cycle.
- ex_branch_taken  in  1  branch/jump resolved taken in EXE.
- mem_stall  in  1  data memory not ready; level-sensitive.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF_ID write enable.
- ifid_flush  out  1  clear IF_ID to a NOP.
- idex_we  out  1  ID_EXE write enable.
- idex_bubble  out  1  load a bubble into ID_EXE (controls zeroed).
- exmem_we  out  1  EXE_MEM write enable.
- exmem_bubble  out  1  load a bubble into EXE_MEM.
- memwb_we  out  1  MEM_WB write enable.
- ex_busy  out  1  a multi-cycle op is in flight.
- stat_stalls  out  CNT_W  stall-cycle count.
- stat_flushes  out  CNT_W  flush count.

Behaviour:
- States: RUN, MULTI. Counter cnt holds log2(16) = 4 bits.
- Outputs are combinational from state and inputs (Mealy). State and cnt are registered.
- Reset (rst_n low, asynchronous, also mid-operation):
  - state = RUN, cnt = 0.
  - All write enables = 0; all flush/bubble = 0; ex_busy = 0.
  - Stats cleared.
- After reset releases, RUN defaults: all write enables = 1, all flush/bubble = 0.
- load_use = id_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
- Priority, highest first: mem_stall > MULTI/ex_multi_start > ex_branch_taken > load_use.
- mem_stall = 1, any state:
  - All write enables = 0; no bubble/flush.
  - State and cnt hold; cnt does not decrement.
- RUN, ex_multi_start = 1:
  - Next state MULTI, cnt = MULTI_LAT - 1.
  - This cycle: pc_we = ifid_we = idex_we = 0; exmem_bubble = 1; memwb_we = 1; ex_busy = 1.
- MULTI:
  - Outputs same as the start cycle (pc_we = ifid_we = idex_we = 0, exmem_bubble = 1, memwb_we = 1, ex_busy = 1).
  - cnt decrements each cycle.
  - When cnt == 1: exmem_bubble = 0, exmem_we = 1 (result captured), ex_busy = 1. Next state RUN, cnt = 0.
  - ex_branch_taken and load_use are ignored in MULTI.
  - Total freeze of the front end = MULTI_LAT cycles.
- RUN, ex_branch_taken = 1: pc_we = 1 (target load), ifid_flush = 1, idex_bubble = 1, all other write enables = 1. A load_use in the same cycle is discarded.
- RUN, load_use = 1: pc_we = 0, ifid_we = 0, idex_bubble = 1; downstream write enables = 1. Exactly one bubble per hazard; no state change.
- ex_rt = 0 never stalls. Back-to-back multi-cycle ops re-enter MULTI immediately after the completing cycle.

Optional Feature:
- Macro: HAZ_STATS_EN.
- Defined:
  - stat_stalls increments on each cycle where pc_we = 0 and rst_n is high.
  - stat_flushes increments on each cycle where ifid_flush = 1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports remain present and are driven constant 0; no counter flops are synthesized.

Test Plan:
- Reset pulse mid-MULTI (cnt = 2) -> all outputs 0 immediately without a clock; after release, state RUN and pc_we = 1 on the next cycle.
- ex_mem_read = 1, ex_rt = 8, id_rs = 8, id_valid = 1 -> exactly one cycle of pc_we = 0, ifid_we = 0, idex_bubble = 1. Same with ex_rt = 0 -> no stall.
- ex_multi_start pulse, MULTI_LAT = 4 -> pc_we low for 4 cycles; exmem_we = 1 only in the 4th cycle; ex_busy low on the 5th.
- ex_branch_taken = 1 together with load_use = 1 -> ifid_flush = 1, idex_bubble = 1, pc_we = 1; no stall cycle follows.
- mem_stall held 3 cycles during MULTI (cnt = 2) -> all write enables 0 for those 3 cycles, then the MULTI countdown resumes from 2.
- HAZ_STATS_EN defined, 1 load-use stall + 4-cycle multi + 1 branch -> stat_stalls = 5, stat_flushes = 1. Undefined -> both read 0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use/branch hazards, multi-cycle EXE freeze and memory wait.
// Optional statistics counters are enabled with the HAZ_STATS_EN macro.
module hazard_stall_controller #(
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_multi_start,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             exmem_bubble,
  output logic             memwb_we,
  output logic             ex_busy,
  output logic [CNT_W-1:0] stat_stalls,
  output logic [CNT_W-1:0] stat_flushes
);

  typedef enum logic [0:0] {RUN = 1'b0, MULTI = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MULTI_LAT - 1);

  state_t     state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       load_use_s;
  logic       pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_bubble_s;
  logic       exmem_we_s, exmem_bubble_s, memwb_we_s, ex_busy_s;

  assign load_use_s = id_valid & ex_mem_read & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // State and countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and Mealy control outputs, priority mem_stall > multi > branch > load-use.
  always_comb begin
    pc_we_s        = 1'b1;
    ifid_we_s      = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_we_s      = 1'b1;
    idex_bubble_s  = 1'b0;
    exmem_we_s     = 1'b1;
    exmem_bubble_s = 1'b0;
    memwb_we_s     = 1'b1;
    ex_busy_s      = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    if (mem_stall) begin
      pc_we_s    = 1'b0;
      ifid_we_s  = 1'b0;
      idex_we_s  = 1'b0;
      exmem_we_s = 1'b0;
      memwb_we_s = 1'b0;
      ex_busy_s  = (state_r == MULTI);
    end else begin
      case (state_r)
        RUN: begin
          if (ex_multi_start) begin
            pc_we_s        = 1'b0;
            ifid_we_s      = 1'b0;
            idex_we_s      = 1'b0;
            exmem_we_s     = 1'b0;
            exmem_bubble_s = 1'b1;
            ex_busy_s      = 1'b1;
            state_nxt_s    = MULTI;
            cnt_nxt_s      = CNT_INIT;
          end else if (ex_branch_taken) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
          end else if (load_use_s) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            idex_bubble_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MULTI: begin
          pc_we_s        = 1'b0;
          ifid_we_s      = 1'b0;
          idex_we_s      = 1'b0;
          exmem_we_s     = 1'b0;
          exmem_bubble_s = 1'b1;
          ex_busy_s      = 1'b1;
          // Last occupied cycle: EXE_MEM captures the result instead of a bubble.
          if (cnt_r == 4'd1) begin
            exmem_bubble_s = 1'b0;
            exmem_we_s     = 1'b1;
            state_nxt_s    = RUN;
            cnt_nxt_s      = 4'd0;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // Reset forces every control low immediately, without waiting for a clock.
  assign pc_we        = rst_n & pc_we_s;
  assign ifid_we      = rst_n & ifid_we_s;
  assign ifid_flush   = rst_n & ifid_flush_s;
  assign idex_we      = rst_n & idex_we_s;
  assign idex_bubble  = rst_n & idex_bubble_s;
  assign exmem_we     = rst_n & exmem_we_s;
  assign exmem_bubble = rst_n & exmem_bubble_s;
  assign memwb_we     = rst_n & memwb_we_s;
  assign ex_busy      = rst_n & ex_busy_s;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stalls_r, flushes_r;

  // Saturating stall and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_r  <= {CNT_W{1'b0}};
      flushes_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_we && (stalls_r != {CNT_W{1'b1}})) begin
        stalls_r <= stalls_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stalls_r <= stalls_r;
      end
      if (ifid_flush && (flushes_r != {CNT_W{1'b1}})) begin
        flushes_r <= flushes_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flushes_r <= flushes_r;
      end
    end
  end

  assign stat_stalls  = stalls_r;
  assign stat_flushes = flushes_r;
`else
  assign stat_stalls  = {CNT_W{1'b0}};
  assign stat_flushes = {CNT_W{1'b0}};
`endif

endmodule
